axi4_tlp_router: RTL and testbench

- Sits directly downstream of axi4_straddle_convertor and consumes its non-straddled 512-bit PCIe TLP stream: one TLP per packet, SOP always on lane 0, packet end marked by TLAST.
- Decodes the BAR ID from the first-beat descriptor and locks the whole packet to one of NUM_PORTS master ports.
- Packets with an unmapped BAR are consumed and dropped.
- Forms the ingress demux of the AXI4 switch.

---
 rtl/tlp_router_pkg.sv | 25 ++
 rtl/axis_pipe_reg.sv | 65 ++++++
 rtl/axi4_tlp_router.sv | 153 +++++++++++++++
 tb/tb_axi4_tlp_router.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_router_pkg.sv
// Shared constants and types for the TLP router: TUSER bit positions,
// BAR ID width, the routing state enum and the BAR map test.
package tlp_router_pkg;

    localparam int SOP0_BIT        = 64;
    localparam int EOP_LSB         = 76;
    localparam int DISCONTINUE_BIT = 96;

    localparam int BAR_ID_W = 3;
    localparam int DATA_W   = 512;
    localparam int KEEP_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    // A BAR is mapped when it names an existing master port.
    function automatic logic bar_mapped(input logic [BAR_ID_W-1:0] bar,
                                        input int                  num_ports);
        return int'({29'd0, bar}) < num_ports;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-entry valid/ready register slice carrying data, user, keep,
// last and a destination index. Accepts a new beat in the same cycle the
// held one drains, so it sustains one beat per cycle.
module axis_pipe_reg #(
    parameter int DATA_W = 512,
    parameter int USER_W = 161,
    parameter int KEEP_W = 16,
    parameter int DEST_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [USER_W-1:0] i_user,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic [DEST_W-1:0] i_dest,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [USER_W-1:0] o_user,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last,
    output logic [DEST_W-1:0] o_dest
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [USER_W-1:0] r_user;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;
    logic [DEST_W-1:0] r_dest;

    assign o_ready = !r_valid || i_ready;

    // Load on upstream handshake; payload holds while downstream stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_dest  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_user <= i_user;
                r_keep <= i_keep;
                r_last <= i_last;
                r_dest <= i_dest;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_user  = r_user;
    assign o_keep  = r_keep;
    assign o_last  = r_last;
    assign o_dest  = r_dest;

endmodule

// File: rtl/axi4_tlp_router.sv
// Ingress demux of the AXI4 switch. Decodes the BAR ID on the first beat
// of each TLP, locks the packet to one master port and forwards it through
// a single register slice; packets with an unmapped BAR are consumed and
// counted.
//
// state | meaning
// IDLE  | waiting for a first beat; decodes BAR
// FWD   | forwarding continuation beats to r_dest
// DROP  | discarding continuation beats of an unmapped packet
module axi4_tlp_router
    import tlp_router_pkg::*;
#(
    parameter int AXI_TUSER_L = 161,
    parameter int NUM_PORTS   = 4,
    parameter int BAR_ID_LSB  = 112
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [AXI_TUSER_L-1:0] S_AXIS_TUSER,
    input  logic [DATA_W-1:0]      S_AXIS_TDATA,
    input  logic [KEEP_W-1:0]      S_AXIS_TKEEP,
    input  logic                   S_AXIS_TLAST,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    output logic [AXI_TUSER_L-1:0] M_AXIS_TUSER,
    output logic [DATA_W-1:0]      M_AXIS_TDATA,
    output logic [KEEP_W-1:0]      M_AXIS_TKEEP,
    output logic                   M_AXIS_TLAST,
    output logic [NUM_PORTS-1:0]   M_AXIS_TVALID,
    input  logic [NUM_PORTS-1:0]   M_AXIS_TREADY,
    output logic [31:0]            drop_count,
    output logic                   error_sop_midpacket
);

    state_t              r_state;
    logic [BAR_ID_W-1:0] r_dest;
    logic [31:0]         r_drop_count;
    logic                r_err;
    logic                r_rdy_en;

    logic [BAR_ID_W-1:0] w_bar;
    logic                w_mapped;
    logic                w_fwd_beat;
    logic                w_hs;
    logic                w_load;
    logic [BAR_ID_W-1:0] w_load_dest;
    logic                w_slice_ready;
    logic                w_out_valid;
    logic [BAR_ID_W-1:0] w_out_dest;
    logic                w_dest_ready;

    assign w_bar    = S_AXIS_TDATA[BAR_ID_LSB +: BAR_ID_W];
    assign w_mapped = bar_mapped(w_bar, NUM_PORTS);

    // Beats that go into the slice; everything else is consumed unconditionally.
    assign w_fwd_beat  = (r_state == FWD) || ((r_state == IDLE) && w_mapped);
    assign w_load_dest = (r_state == IDLE) ? w_bar : r_dest;

    // Ready is held low through reset and its first release edge.
    assign S_AXIS_TREADY = r_rdy_en && (w_fwd_beat ? w_slice_ready : 1'b1);
    assign w_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign w_load        = w_hs && w_fwd_beat;

    axis_pipe_reg #(
        .DATA_W (DATA_W),
        .USER_W (AXI_TUSER_L),
        .KEEP_W (KEEP_W),
        .DEST_W (BAR_ID_W)
    ) u_slice (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .i_valid (w_load),
        .o_ready (w_slice_ready),
        .i_data  (S_AXIS_TDATA),
        .i_user  (S_AXIS_TUSER),
        .i_keep  (S_AXIS_TKEEP),
        .i_last  (S_AXIS_TLAST),
        .i_dest  (w_load_dest),
        .o_valid (w_out_valid),
        .i_ready (w_dest_ready),
        .o_data  (M_AXIS_TDATA),
        .o_user  (M_AXIS_TUSER),
        .o_keep  (M_AXIS_TKEEP),
        .o_last  (M_AXIS_TLAST),
        .o_dest  (w_out_dest)
    );

    // Select the ready of the port currently owning the slice.
    always_comb begin
        w_dest_ready = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_out_dest == BAR_ID_W'(i)) begin
                w_dest_ready = M_AXIS_TREADY[i];
            end
        end
    end

    // One-hot valid: only the slice's destination port sees the beat.
    always_comb begin
        M_AXIS_TVALID = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            M_AXIS_TVALID[i] = w_out_valid && (w_out_dest == BAR_ID_W'(i));
        end
    end

    // Routing FSM, drop counter and mid-packet SOP pulse; advances on slave handshake.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= IDLE;
            r_dest       <= '0;
            r_drop_count <= '0;
            r_err        <= 1'b0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_err    <= w_hs && (r_state != IDLE) && S_AXIS_TUSER[SOP0_BIT];
            if (w_hs) begin
                case (r_state)
                    IDLE: begin
                        if (w_mapped) begin
                            r_dest <= w_bar;
                            if (!S_AXIS_TLAST) begin
                                r_state <= FWD;
                            end
                        end else begin
                            if (r_drop_count != 32'hFFFF_FFFF) begin
                                r_drop_count <= r_drop_count + 32'd1;
                            end
                            if (!S_AXIS_TLAST) begin
                                r_state <= DROP;
                            end
                        end
                    end
                    FWD: begin
                        if (S_AXIS_TLAST) begin
                            r_state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (S_AXIS_TLAST) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign drop_count          = r_drop_count;
    assign error_sop_midpacket = r_err;

endmodule

// File: tb/tb_axi4_tlp_router.sv
// Scoreboard bench for axi4_tlp_router: the stimulus side pushes expected
// master beats, a monitor pops and compares them as the DUT presents them.
module tb_axi4_tlp_router;
    import tlp_router_pkg::*;

    localparam int NP     = 4;
    localparam int USER_W = 161;
    localparam int BLSB   = 112;

    logic              ACLK;
    logic              ARESETN;
    logic [USER_W-1:0] S_AXIS_TUSER;
    logic [511:0]      S_AXIS_TDATA;
    logic [15:0]       S_AXIS_TKEEP;
    logic              S_AXIS_TLAST;
    logic              S_AXIS_TVALID;
    logic              S_AXIS_TREADY;
    logic [USER_W-1:0] M_AXIS_TUSER;
    logic [511:0]      M_AXIS_TDATA;
    logic [15:0]       M_AXIS_TKEEP;
    logic              M_AXIS_TLAST;
    logic [NP-1:0]     M_AXIS_TVALID;
    logic [NP-1:0]     M_AXIS_TREADY;
    logic [31:0]       drop_count;
    logic              error_sop_midpacket;

    axi4_tlp_router #(
        .AXI_TUSER_L (USER_W),
        .NUM_PORTS   (NP),
        .BAR_ID_LSB  (BLSB)
    ) dut (
        .ACLK                (ACLK),
        .ARESETN             (ARESETN),
        .S_AXIS_TUSER        (S_AXIS_TUSER),
        .S_AXIS_TDATA        (S_AXIS_TDATA),
        .S_AXIS_TKEEP        (S_AXIS_TKEEP),
        .S_AXIS_TLAST        (S_AXIS_TLAST),
        .S_AXIS_TVALID       (S_AXIS_TVALID),
        .S_AXIS_TREADY       (S_AXIS_TREADY),
        .M_AXIS_TUSER        (M_AXIS_TUSER),
        .M_AXIS_TDATA        (M_AXIS_TDATA),
        .M_AXIS_TKEEP        (M_AXIS_TKEEP),
        .M_AXIS_TLAST        (M_AXIS_TLAST),
        .M_AXIS_TVALID       (M_AXIS_TVALID),
        .M_AXIS_TREADY       (M_AXIS_TREADY),
        .drop_count          (drop_count),
        .error_sop_midpacket (error_sop_midpacket)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int                port;
        logic [511:0]      data;
        logic [USER_W-1:0] user;
        logic [15:0]       keep;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    pop_cyc[$];
    int    cyc;
    int    tests;
    int    fails;

    // Reference model of the router state
    int          m_state;   // 0 idle, 1 forwarding, 2 dropping
    int          m_port;
    logic [31:0] m_drops;
    logic        exp_err;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the queue head
    initial begin
        cyc = 0;
        forever begin
            @(negedge ACLK);
            #2;
            cyc++;
            if (ARESETN === 1'b1 && (|M_AXIS_TVALID)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got tvalid %0h expected none", M_AXIS_TVALID);
                end else begin
                    beat_t       e;
                    logic [NP-1:0] ev;
                    e  = exp_q[0];
                    ev = NP'(1 << e.port);
                    chk("m_tvalid", 512'(M_AXIS_TVALID), 512'(ev));
                    chk("m_tdata", M_AXIS_TDATA, e.data);
                    chk("m_tuser", 512'(M_AXIS_TUSER), 512'(e.user));
                    chk("m_tkeep", 512'(M_AXIS_TKEEP), 512'(e.keep));
                    chk("m_tlast", 512'(M_AXIS_TLAST), 512'(e.last));
                    if ((M_AXIS_TVALID & M_AXIS_TREADY) != '0) begin
                        void'(exp_q.pop_front());
                        pop_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input logic [2:0] bar, input logic [63:0] low, input logic last,
                         input logic sop, input logic disc);
        logic [511:0]      d;
        logic [USER_W-1:0] u;
        @(negedge ACLK);
        d = '0;
        d[BLSB +: 3] = bar;
        d[63:0] = low;
        u = '0;
        u[SOP0_BIT] = sop;
        u[DISCONTINUE_BIT] = disc;
        u[7:0] = low[7:0];
        S_AXIS_TDATA  = d;
        S_AXIS_TUSER  = u;
        S_AXIS_TKEEP  = last ? 16'h00FF : 16'hFFFF;
        S_AXIS_TLAST  = last;
        S_AXIS_TVALID = 1'b1;
    endtask

    // Wait for the slave handshake, update the model, check pulse and counter
    task automatic wait_hs(output int waits);
        int    bar;
        logic  mid;
        beat_t b;
        waits = 0;
        forever begin
            #1;
            if (S_AXIS_TREADY === 1'b1) break;
            @(negedge ACLK);
            waits++;
            if (waits > 50) begin
                tests++;
                fails++;
                $display("FAIL hs_timeout: got no handshake expected one within 50 cycles");
                S_AXIS_TVALID = 1'b0;
                return;
            end
        end
        @(posedge ACLK);
        bar    = int'(S_AXIS_TDATA[BLSB +: 3]);
        mid    = (m_state != 0);
        b.data = S_AXIS_TDATA;
        b.user = S_AXIS_TUSER;
        b.keep = S_AXIS_TKEEP;
        b.last = S_AXIS_TLAST;
        if (m_state == 0) begin
            if (bar < NP) begin
                b.port = bar;
                exp_q.push_back(b);
                m_port  = bar;
                m_state = S_AXIS_TLAST ? 0 : 1;
            end else begin
                m_drops = m_drops + 1;
                m_state = S_AXIS_TLAST ? 0 : 2;
            end
        end else if (m_state == 1) begin
            b.port = m_port;
            exp_q.push_back(b);
            if (S_AXIS_TLAST) m_state = 0;
        end else begin
            if (S_AXIS_TLAST) m_state = 0;
        end
        exp_err = mid && S_AXIS_TUSER[SOP0_BIT];
        #2;
        S_AXIS_TVALID = 1'b0;
        chk("err_pulse", 512'(error_sop_midpacket), 512'(exp_err));
        chk("drop_count", 512'(drop_count), 512'(m_drops));
    endtask

    task automatic drain();
        repeat (4) @(negedge ACLK);
        chk("queue_drained", 512'(exp_q.size()), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int n;
        tests = 0;
        fails = 0;
        m_state = 0;
        m_port  = 0;
        m_drops = '0;
        S_AXIS_TUSER  = '0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = '1;
        ARESETN = 1'b1;
        #1 ARESETN = 1'b0;
        #1;
        chk("rst_s_tready", 512'(S_AXIS_TREADY), 512'(0));
        chk("rst_m_tvalid", 512'(M_AXIS_TVALID), 512'(0));
        chk("rst_m_tdata", M_AXIS_TDATA, 512'(0));
        chk("rst_drop_count", 512'(drop_count), 512'(0));
        chk("rst_err", 512'(error_sop_midpacket), 512'(0));
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        chk("ready_after_release", 512'(S_AXIS_TREADY), 512'(1));

        // Two-beat TLP to port 2
        drive(3'd2, 64'hAA, 1'b0, 1'b1, 1'b0);
        wait_hs(w);
        drive(3'd6, 64'hBB, 1'b1, 1'b0, 1'b0);
        wait_hs(w);
        chk("t1_no_stall", 512'(w), 512'(0));
        drain();
        n = pop_cyc.size();
        chk("t1_consecutive", 512'(pop_cyc[n-1] - pop_cyc[n-2]), 512'(1));

        // Back-to-back single-beat packets to ports 0 and 3
        drive(3'd0, 64'h01, 1'b1, 1'b1, 1'b0);
        wait_hs(w);
        chk("t2_ready_a", 512'(w), 512'(0));
        drive(3'd3, 64'h02, 1'b1, 1'b1, 1'b0);
        wait_hs(w);
        chk("t2_ready_b", 512'(w), 512'(0));
        drain();
        n = pop_cyc.size();
        chk("t2_adjacent", 512'(pop_cyc[n-1] - pop_cyc[n-2]), 512'(1));

        // Unmapped BAR 5: three beats consumed and dropped, then BAR 1 routes
        drive(3'd5, 64'h61, 1'b0, 1'b1, 1'b0);
        wait_hs(w);
        chk("t3_drop_rdy0", 512'(w), 512'(0));
        drive(3'd1, 64'h62, 1'b0, 1'b0, 1'b0);
        wait_hs(w);
        chk("t3_drop_rdy1", 512'(w), 512'(0));
        drive(3'd1, 64'h63, 1'b1, 1'b0, 1'b0);
        wait_hs(w);
        chk("t3_drop_rdy2", 512'(w), 512'(0));
        drive(3'd1, 64'h71, 1'b1, 1'b1, 1'b1);
        wait_hs(w);
        drain();

        // Port 1 stalled for 4 cycles: output held, slave blocked
        @(negedge ACLK);
        M_AXIS_TREADY = 4'b1101;
        drive(3'd1, 64'h11, 1'b0, 1'b1, 1'b0);
        wait_hs(w);
        drive(3'd0, 64'h22, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_s_tready_low", 512'(S_AXIS_TREADY), 512'(0));
            chk("t4_data_held", 512'(M_AXIS_TDATA[63:0]), 512'(64'h11));
            chk("t4_tvalid_held", 512'(M_AXIS_TVALID), 512'(4'b0010));
            @(negedge ACLK);
        end
        M_AXIS_TREADY = '1;
        wait_hs(w);
        drain();

        // Mid-packet SOP pulse, beat stays on port 2
        drive(3'd2, 64'h31, 1'b0, 1'b1, 1'b0);
        wait_hs(w);
        drive(3'd7, 64'h32, 1'b0, 1'b1, 1'b0);
        wait_hs(w);
        @(posedge ACLK);
        #2;
        chk("t5_err_one_cycle", 512'(error_sop_midpacket), 512'(0));
        drive(3'd0, 64'h33, 1'b1, 1'b0, 1'b0);
        wait_hs(w);
        drain();

        // Reset during beat 2 of a 4-beat packet
        drive(3'd2, 64'h41, 1'b0, 1'b1, 1'b0);
        wait_hs(w);
        drive(3'd0, 64'h42, 1'b0, 1'b0, 1'b0);
        #3 ARESETN = 1'b0;
        #1;
        chk("t6_rst_tvalid", 512'(M_AXIS_TVALID), 512'(0));
        chk("t6_rst_tdata", M_AXIS_TDATA, 512'(0));
        chk("t6_rst_tlast", 512'(M_AXIS_TLAST), 512'(0));
        chk("t6_rst_tuser", 512'(M_AXIS_TUSER), 512'(0));
        chk("t6_rst_s_tready", 512'(S_AXIS_TREADY), 512'(0));
        chk("t6_rst_drop_count", 512'(drop_count), 512'(0));
        S_AXIS_TVALID = 1'b0;
        exp_q.delete();
        m_state = 0;
        m_drops = '0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        drive(3'd3, 64'h51, 1'b1, 1'b1, 1'b0);
        wait_hs(w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
